// File: rtl/scan_line_encoder.sv
// Sequential line encoder: turns a multi-hot 7-line vector into one {x,y,z}
// code per active line, handed out over a valid/ready stream.
`timescale 1ns/1ps
module scan_line_encoder #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] d_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        EMPTY = 2'd2
    } state_t;

    state_t     state;
    logic [6:0] pending;
    logic [6:0] remain;

    // Index (1..7) of the next line to emit, honouring the scan direction
    function automatic logic [2:0] pick(input logic [6:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (LSB_FIRST) begin
                if (p[6-i]) idx = 3'(7 - i);
            end else begin
                if (p[i]) idx = 3'(i + 1);
            end
        end
        return idx;
    endfunction

    function automatic logic single(input logic [6:0] p);
        return (p != 7'd0) && ((p & (p - 7'd1)) == 7'd0);
    endfunction

    assign remain = pending & ~(7'd1 << (code - 3'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 7'd0;
            code      <= 3'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            frame_cnt <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        pending   <= d_in;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        if (d_in == 7'd0) begin
                            state    <= EMPTY;
                            code     <= 3'd0;
                            out_last <= 1'b1;
                        end else begin
                            state    <= EMIT;
                            code     <= pick(d_in);
                            out_last <= single(d_in);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        pending <= remain;
                        if (out_last) begin
                            state     <= IDLE;
                            frame_cnt <= frame_cnt + 8'd1;
                            code      <= 3'd0;
                            out_last  <= 1'b0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            code     <= pick(remain);
                            out_last <= single(remain);
                        end
                    end
                end
                EMPTY: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        frame_cnt <= frame_cnt + 8'd1;
                        out_last  <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pending   <= 7'd0;
                    code      <= 3'd0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_line_encoder.sv
// Bench for scan_line_encoder: both scan directions run in lockstep against a
// queue-based reference of expected codes per vector.
`timescale 1ns/1ps
module tb_scan_line_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] d_in = 7'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, out_valid_a, out_last_a;
    logic       in_ready_d, out_valid_d, out_last_d;
    logic [2:0] code_a, code_d;
    logic [7:0] frame_cnt_a, frame_cnt_d;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] fc_model = 8'd0;

    always #5 clk = ~clk;

    scan_line_encoder #(.LSB_FIRST(1'b1)) dut_asc (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .in_valid(in_valid),
        .in_ready(in_ready_a), .code(code_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last(out_last_a), .frame_cnt(frame_cnt_a)
    );

    scan_line_encoder #(.LSB_FIRST(1'b0)) dut_desc (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .in_valid(in_valid),
        .in_ready(in_ready_d), .code(code_d), .out_valid(out_valid_d),
        .out_ready(out_ready), .out_last(out_last_d), .frame_cnt(frame_cnt_d)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready_a"}, 8'(in_ready_a), 8'd1);
        check({tag, " out_valid_a"}, 8'(out_valid_a), 8'd0);
        check({tag, " in_ready_d"}, 8'(in_ready_d), 8'd1);
        check({tag, " out_valid_d"}, 8'(out_valid_d), 8'd0);
        check({tag, " frame_cnt_a"}, frame_cnt_a, fc_model);
        check({tag, " frame_cnt_d"}, frame_cnt_d, fc_model);
    endtask

    // Hand one vector in, then drain its codes; stall_first cycles of
    // backpressure up front, then random or full readiness.
    task automatic run_vec(input logic [6:0] d, input int stall_first,
                           input bit rnd, input string tag);
        int   asc[$];
        int   desc[$];
        int   k;
        int   cyc;
        bit   r;
        asc  = {};
        desc = {};
        for (int i = 1; i <= 7; i++)
            if (d[i-1]) asc.push_back(i);
        if (asc.size() == 0) asc.push_back(0);
        for (int i = asc.size() - 1; i >= 0; i--) desc.push_back(asc[i]);

        d_in     = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        d_in = 7'h7f;
        k    = 0;
        cyc  = 0;
        while (k < asc.size() && cyc < 100) begin
            @(negedge clk);
            check({tag, " valid_a"}, 8'(out_valid_a), 8'd1);
            check({tag, " valid_d"}, 8'(out_valid_d), 8'd1);
            check({tag, " code_a"}, 8'(code_a), 8'(asc[k]));
            check({tag, " code_d"}, 8'(code_d), 8'(desc[k]));
            check({tag, " last_a"}, 8'(out_last_a), 8'(k == asc.size() - 1));
            check({tag, " last_d"}, 8'(out_last_d), 8'(k == asc.size() - 1));
            if (cyc < stall_first) r = 1'b0;
            else if (rnd) r = 1'($urandom_range(0, 1));
            else r = 1'b1;
            out_ready = r;
            @(posedge clk);
            if (r) k++;
            cyc++;
        end
        check({tag, " timeout"}, 8'(k == asc.size()), 8'd1);
        fc_model = fc_model + 8'd1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_idle({tag, " end"});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle("reset");
        check("reset code_a", 8'(code_a), 8'd0);
        check("reset last_a", 8'(out_last_a), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(7'b0000010, 0, 1'b0, "single");
        run_vec(7'b1010101, 0, 1'b0, "multi");
        run_vec(7'b1000011, 0, 1'b0, "multi_desc");
        run_vec(7'b0000000, 0, 1'b0, "empty");
        run_vec(7'b0100100, 3, 1'b0, "stall");
        for (int v = 0; v < 20; v++)
            run_vec(7'($urandom_range(0, 127)), 0, 1'b1, "rand");

        d_in      = 7'h7f;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        fc_model = 8'd0;
        #1;
        check_idle("async_rst");
        check("async_rst last_a", 8'(out_last_a), 8'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        for (int v = 0; v < 256; v++)
            run_vec(7'($urandom_range(0, 127)), 0, 1'b1, "wrap");
        check("wrap frame_cnt_a", frame_cnt_a, 8'd0);
        check("wrap frame_cnt_d", frame_cnt_d, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
